// File: rtl/pixel_feed_ctrl.sv
// pixel_feed_ctrl: frame sequencer that feeds upstream pixels to the context modeller.
// Build macro PIXEL_FEED_LINE_GAP_EN adds the line_gap input and the GAP state.
module pixel_feed_ctrl #(
    parameter int LINE_W    = 512,
    parameter int ROW_W     = 10,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROW_W-1:0] img_rows,
`ifdef PIXEL_FEED_LINE_GAP_EN
    input  logic [3:0]       line_gap,
`endif
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    input  logic             stall,
    output logic             ctx_en,
    output logic [7:0]       ctx_data,
    output logic             ctx_rst_n,
    output logic             busy,
    output logic             frame_done,
    output logic [8:0]       col_cnt,
    output logic [ROW_W-1:0] row_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [8:0]    COL_LAST   = 9'(LINE_W - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
`ifdef PIXEL_FEED_LINE_GAP_EN
        , GAP
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ROW_W-1:0] rows_q;
    logic             flush_q;
    logic [DW-1:0]    drain_q;
    logic             xfer;
    logic             last_col;
    logic             last_row;
    logic             drain_adv;
    logic             accept;
`ifdef PIXEL_FEED_LINE_GAP_EN
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt_q;
`endif

    // Drain counts only once the last pixel has left ctx_data.
    always_comb begin
        state_d    = state_q;
        pix_ready  = (state_q == RUN) && !stall;
        xfer       = pix_valid && pix_ready;
        accept     = (state_q == IDLE) && start;
        last_col   = (col_cnt == COL_LAST);
        last_row   = (row_cnt == rows_q - ROW_W'(1));
        drain_adv  = !stall && !ctx_en;
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_q)
                    state_d = (rows_q == '0) ? DONE : RUN;
            end
            RUN: begin
                if (xfer && last_col) begin
                    if (last_row)
                        state_d = DRAIN;
`ifdef PIXEL_FEED_LINE_GAP_EN
                    else if (gap_q != 4'd0)
                        state_d = GAP;
`endif
                end
            end
`ifdef PIXEL_FEED_LINE_GAP_EN
            GAP: begin
                if (gap_cnt_q == gap_q - 4'd1)
                    state_d = RUN;
            end
`endif
            DRAIN: begin
                if (drain_adv && drain_q == DRAIN_LAST)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ctx_rst_n <= 1'b0;
            ctx_en    <= 1'b0;
            ctx_data  <= '0;
        end else begin
            state_q   <= state_d;
            ctx_rst_n <= (state_d != FLUSH);
            ctx_en    <= xfer;
            if (xfer)
                ctx_data <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            flush_q <= 1'b0;
            drain_q <= '0;
        end else begin
            if (accept) begin
                rows_q  <= img_rows;
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (xfer) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + 9'd1;
                end
            end
            flush_q <= (state_q == FLUSH) && !flush_q;
            if (state_q != DRAIN)
                drain_q <= '0;
            else if (drain_adv)
                drain_q <= drain_q + DW'(1);
        end
    end

`ifdef PIXEL_FEED_LINE_GAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            if (accept)
                gap_q <= line_gap;
            if (state_q == GAP)
                gap_cnt_q <= gap_cnt_q + 4'd1;
            else
                gap_cnt_q <= '0;
        end
    end
`endif

endmodule

// File: doc/pixel_feed_ctrl.md
PIXEL_FEED_CTRL -- requirements
Module: pixel_feed_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 512, meaning pixels per line; it matches the context modeller row-buffer depth.
REQ-002 SHALL have parameter ROW_W, default 10, meaning width of the row count and row counter.
REQ-003 SHALL have parameter DRAIN_CYC, default 3, meaning cycles waited after the last pixel before frame_done.
REQ-004 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, frame start request; sampled only in IDLE.
REQ-007 SHALL have port img_rows, input, ROW_W, number of lines in the frame; sampled on accepted start.
REQ-008 SHALL have port pix_valid, input, 1, upstream pixel valid.
REQ-009 SHALL have port pix_data, input, 8, upstream pixel.
REQ-010 SHALL have port pix_ready, output, 1, upstream ready; combinational.
REQ-011 SHALL have port stall, input, 1, downstream encoder backpressure.
REQ-012 SHALL have port ctx_en, output, 1, context modeller enable, registered.
REQ-013 SHALL have port ctx_data, output, 8, context modeller pixel, registered.
REQ-014 SHALL have port ctx_rst_n, output, 1, active-low clear to the context modeller, registered.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port frame_done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port col_cnt, output, 9, current column.
REQ-018 SHALL have port row_cnt, output, ROW_W, current row.

Function
REQ-019 SHALL implement the states IDLE, FLUSH, RUN, GAP, DRAIN and DONE.
REQ-020 SHALL, in IDLE with start=1, latch img_rows, clear both counters and enter FLUSH; start in any other state SHALL be ignored.
REQ-021 SHALL drive ctx_rst_n=0 for exactly 2 cycles in FLUSH, then enter RUN; if the latched img_rows is 0, it SHALL enter DONE instead.
REQ-022 SHALL drive pix_ready = (state==RUN) & !stall; a transfer occurs on pix_valid & pix_ready.
REQ-023 SHALL, one cycle after each transfer, set ctx_en=1 and ctx_data to the transferred pixel; otherwise ctx_en=0 and ctx_data keeps its value.
REQ-024 SHALL increment col_cnt on each transfer, wrapping from LINE_W-1 to 0, and increment row_cnt at the wrap.
REQ-025 SHALL, on the transfer of column LINE_W-1 of row img_rows-1, enter DRAIN; no further transfers SHALL occur in that frame.
REQ-026 SHALL hold DRAIN for DRAIN_CYC cycles, then enter DONE.
REQ-027 SHALL pulse frame_done for the one DONE cycle, then return to IDLE.
REQ-028 SHALL not advance the DRAIN count while stall=1.
REQ-029 SHALL, when stall and pix_valid are both high, make no transfer and leave the counters unchanged.

Reset
REQ-030 SHALL, on reset=0 at any time including mid-frame, force state=IDLE, pix_ready=0, ctx_en=0, ctx_data=0, ctx_rst_n=0, busy=0, frame_done=0, col_cnt=0 and row_cnt=0.
REQ-031 SHALL hold ctx_rst_n=0 during reset and drive it 1 from the first clock edge after release, except in FLUSH.

Configuration
REQ-032 SHALL, with macro PIXEL_FEED_LINE_GAP_EN defined, add input line_gap[3:0], sampled on accepted start; after each line wrap that is not the last line, the block SHALL enter GAP for line_gap cycles with pix_ready=0, then return to RUN, and line_gap=0 SHALL skip GAP.
REQ-033 SHALL, without PIXEL_FEED_LINE_GAP_EN, have no line_gap port and no GAP state, so RUN continues directly across line boundaries.

Verification
REQ-034 SHALL verify: reset, then start with img_rows=2 and pix_valid held at 1 -> 2 ctx_rst_n-low cycles, 1024 ctx_en pulses, row_cnt 0 to 1 at transfer 512, frame_done 4 cycles after the last ctx_en (DRAIN_CYC=3).
REQ-035 SHALL verify: stall=1 for 10 cycles at column 100 -> pix_ready=0, col_cnt holds at 100, no ctx_en during the stall, resumes with no pixel lost or duplicated.
REQ-036 SHALL verify: start with img_rows=0 -> FLUSH, then a frame_done pulse, no ctx_en.
REQ-037 SHALL verify: reset pulsed at row 1 column 37 -> all outputs at their reset values; a new start -> clean frame from column 0 row 0.
REQ-038 SHALL verify: start re-asserted during RUN -> ignored, frame completes normally.
REQ-039 SHALL verify: with PIXEL_FEED_LINE_GAP_EN and line_gap=5, img_rows=3 -> exactly 5 pix_ready-low cycles after lines 0 and 1, none after line 2.
